// File: rtl/multi_clip_controller.sv
`default_nettype none
// ============================================================================
// Module      : multi_clip_controller
// Description : Multi-slot audio clip recorder/player sequencing one shared
//               sample memory between a deserializer and a serializer.
// Revision    : 1.0
// ============================================================================
module multi_clip_controller #(
    parameter int NUM_CLIPS       = 4,
    parameter int CLIP_ADDR_WIDTH = 12,
    parameter int SAMPLE_WIDTH    = 16,
    localparam int SEL_W          = $clog2(NUM_CLIPS)
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               play_command_i,
    input  logic                               record_command_i,
    input  logic                               play_clip_select_i,
    input  logic                               record_clip_select_i,
    input  logic                               loop_mode_i,
    output logic [SEL_W-1:0]                   play_clip_o,
    output logic [SEL_W-1:0]                   record_clip_o,
    output logic [NUM_CLIPS-1:0]               clip_valid_o,
    output logic                               busy_o,
    output logic                               deserializer_enable_o,
    input  logic                               deserializer_done_i,
    input  logic [SAMPLE_WIDTH-1:0]            deserializer_data_i,
    output logic                               serializer_enable_o,
    input  logic                               serializer_done_i,
    output logic [SAMPLE_WIDTH-1:0]            serializer_data_o,
    output logic [SEL_W+CLIP_ADDR_WIDTH-1:0]   memory_addr_o,
    output logic                               memory_en_o,
    output logic                               memory_we_o,
    output logic [SAMPLE_WIDTH-1:0]            memory_wdata_o,
    input  logic [SAMPLE_WIDTH-1:0]            memory_rdata_i
);

    localparam int LEN_W = CLIP_ADDR_WIDTH + 1;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] REC_WAIT   = 3'd1;
    localparam logic [2:0] REC_WRITE  = 3'd2;
    localparam logic [2:0] PLAY_READ  = 3'd3;
    localparam logic [2:0] PLAY_LATCH = 3'd4;
    localparam logic [2:0] PLAY_WAIT  = 3'd5;

    logic [2:0]                 state;
    logic [SEL_W-1:0]           play_clip;
    logic [SEL_W-1:0]           record_clip;
    logic [CLIP_ADDR_WIDTH-1:0] offset;
    logic [SAMPLE_WIDTH-1:0]    sample;
    logic [SAMPLE_WIDTH-1:0]    serializer_data;
    logic                       stop_pending;
    logic [LEN_W-1:0]           clip_length [NUM_CLIPS];
    logic [LEN_W-1:0]           next_count;

    assign next_count = {1'b0, offset} + LEN_W'(1);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state           <= IDLE;
            play_clip       <= '0;
            record_clip     <= '0;
            offset          <= '0;
            sample          <= '0;
            serializer_data <= '0;
            stop_pending    <= 1'b0;
            for (int k = 0; k < NUM_CLIPS; k++) begin
                clip_length[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (play_clip_select_i)   play_clip   <= play_clip + SEL_W'(1);
                    if (record_clip_select_i) record_clip <= record_clip + SEL_W'(1);
                    // Record takes priority over a simultaneous play request.
                    if (record_command_i) begin
                        offset                   <= '0;
                        clip_length[record_clip] <= '0;
                        stop_pending             <= 1'b0;
                        state                    <= REC_WAIT;
                    end else if (play_command_i && (clip_length[play_clip] != '0)) begin
                        offset <= '0;
                        state  <= PLAY_READ;
                    end
                end
                REC_WAIT: begin
                    if (deserializer_done_i) begin
                        sample       <= deserializer_data_i;
                        stop_pending <= record_command_i;
                        state        <= REC_WRITE;
                    end else if (record_command_i) begin
                        state <= IDLE;
                    end
                end
                REC_WRITE: begin
                    clip_length[record_clip] <= next_count;
                    offset                   <= offset + CLIP_ADDR_WIDTH'(1);
                    if ((&offset) || stop_pending || record_command_i) state <= IDLE;
                    else                                                state <= REC_WAIT;
                end
                PLAY_READ: begin
                    state <= play_command_i ? IDLE : PLAY_LATCH;
                end
                PLAY_LATCH: begin
                    serializer_data <= memory_rdata_i;
                    state           <= play_command_i ? IDLE : PLAY_WAIT;
                end
                PLAY_WAIT: begin
                    if (play_command_i) begin
                        state <= IDLE;
                    end else if (serializer_done_i) begin
                        if (next_count < clip_length[play_clip]) begin
                            offset <= offset + CLIP_ADDR_WIDTH'(1);
                            state  <= PLAY_READ;
                        end else if (loop_mode_i) begin
                            offset <= '0;
                            state  <= PLAY_READ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CLIPS; k++) begin : g_valid
        assign clip_valid_o[k] = |clip_length[k];
    end

    assign play_clip_o           = play_clip;
    assign record_clip_o         = record_clip;
    assign busy_o                = (state != IDLE);
    assign deserializer_enable_o = (state == REC_WAIT) || (state == REC_WRITE);
    // A stop request removes the enable in the same cycle it arrives.
    assign serializer_enable_o   = (state == PLAY_WAIT) && !play_command_i;
    assign serializer_data_o     = serializer_data;
    assign memory_en_o           = (state == REC_WRITE) || (state == PLAY_READ);
    assign memory_we_o           = (state == REC_WRITE);
    assign memory_wdata_o        = (state == REC_WRITE) ? sample : '0;
    assign memory_addr_o         = (state == REC_WRITE) ? {record_clip, offset} :
                                   (state == PLAY_READ) ? {play_clip, offset}   : '0;

endmodule
`default_nettype wire

// File: tb/tb_multi_clip_controller.sv
`default_nettype none
// Testbench for multi_clip_controller: default instance plus a 4-deep-clip instance.
module tb_multi_clip_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance (default parameters)
    logic        reset_i, play_cmd, rec_cmd, play_sel, rec_sel, loop_mode;
    logic        des_done, ser_done;
    logic [15:0] des_data, mem_rdata;
    logic [1:0]  play_clip, rec_clip;
    logic [3:0]  clip_valid;
    logic        busy, des_en, ser_en, mem_en, mem_we;
    logic [15:0] ser_data, mem_wdata;
    logic [13:0] mem_addr;

    multi_clip_controller dut (
        .clock_i(clk), .reset_i(reset_i),
        .play_command_i(play_cmd), .record_command_i(rec_cmd),
        .play_clip_select_i(play_sel), .record_clip_select_i(rec_sel),
        .loop_mode_i(loop_mode),
        .play_clip_o(play_clip), .record_clip_o(rec_clip),
        .clip_valid_o(clip_valid), .busy_o(busy),
        .deserializer_enable_o(des_en), .deserializer_done_i(des_done),
        .deserializer_data_i(des_data),
        .serializer_enable_o(ser_en), .serializer_done_i(ser_done),
        .serializer_data_o(ser_data),
        .memory_addr_o(mem_addr), .memory_en_o(mem_en), .memory_we_o(mem_we),
        .memory_wdata_o(mem_wdata), .memory_rdata_i(mem_rdata)
    );

    // Small instance: 4-sample clips
    logic        s_play_cmd, s_rec_cmd, s_des_done, s_ser_done;
    logic [15:0] s_des_data, s_mem_rdata;
    logic [1:0]  s_play_clip, s_rec_clip;
    logic [3:0]  s_clip_valid;
    logic        s_busy, s_des_en, s_ser_en, s_mem_en, s_mem_we;
    logic [15:0] s_ser_data, s_mem_wdata;
    logic [3:0]  s_mem_addr;

    multi_clip_controller #(.CLIP_ADDR_WIDTH(2)) dut_small (
        .clock_i(clk), .reset_i(reset_i),
        .play_command_i(s_play_cmd), .record_command_i(s_rec_cmd),
        .play_clip_select_i(1'b0), .record_clip_select_i(1'b0),
        .loop_mode_i(1'b0),
        .play_clip_o(s_play_clip), .record_clip_o(s_rec_clip),
        .clip_valid_o(s_clip_valid), .busy_o(s_busy),
        .deserializer_enable_o(s_des_en), .deserializer_done_i(s_des_done),
        .deserializer_data_i(s_des_data),
        .serializer_enable_o(s_ser_en), .serializer_done_i(s_ser_done),
        .serializer_data_o(s_ser_data),
        .memory_addr_o(s_mem_addr), .memory_en_o(s_mem_en), .memory_we_o(s_mem_we),
        .memory_wdata_o(s_mem_wdata), .memory_rdata_i(s_mem_rdata)
    );

    // Memory models and write monitors
    logic [15:0] mem   [0:16383];
    logic [15:0] s_mem [0:15];
    logic [29:0] exp_wr_q[$], obs_wr_q[$];
    logic [19:0] s_exp_wr_q[$], s_obs_wr_q[$];
    logic [15:0] exp_ser_q[$];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            obs_wr_q.push_back({mem_addr, mem_wdata});
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
        end
        if (s_mem_en && s_mem_we) begin
            s_mem[s_mem_addr] <= s_mem_wdata;
            s_obs_wr_q.push_back({s_mem_addr, s_mem_wdata});
        end else if (s_mem_en) begin
            s_mem_rdata <= s_mem[s_mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rec_sel();
        rec_sel = 1'b1; tick(); rec_sel = 1'b0; tick();
    endtask

    task automatic pulse_play_sel();
        play_sel = 1'b1; tick(); play_sel = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, play_clip, rec_clip, clip_valid} !== 9'd0) begin
            errors++;
            $display("FAIL reset_status busy/play/rec/valid=%b required 0", {busy, play_clip, rec_clip, clip_valid});
        end
        checks++;
        if ({des_en, ser_en, mem_en, mem_we, mem_addr, mem_wdata, ser_data} !== 50'd0) begin
            errors++;
            $display("FAIL reset_datapath en=%b addr=%h wdata=%h sdata=%h required all 0",
                     {des_en, ser_en, mem_en, mem_we}, mem_addr, mem_wdata, ser_data);
        end
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_select_wrap();
        for (int i = 0; i < 5; i++) pulse_rec_sel();
        checks++;
        if (rec_clip !== 2'd1) begin
            errors++; $display("FAIL rec_select_wrap got %0d required 1", rec_clip);
        end
        pulse_play_sel(); pulse_play_sel();
        checks++;
        if (play_clip !== 2'd2) begin
            errors++; $display("FAIL play_select got %0d required 2", play_clip);
        end
        pulse_rec_sel();
        checks++;
        if (rec_clip !== 2'd2) begin
            errors++; $display("FAIL rec_select got %0d required 2", rec_clip);
        end
    endtask

    task automatic test_record();
        logic [15:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        rec_cmd = 1'b1; tick(); rec_cmd = 1'b0;
        checks++;
        if (busy !== 1'b1 || des_en !== 1'b1) begin
            errors++; $display("FAIL rec_start busy=%b des_en=%b required 1 1", busy, des_en);
        end
        pulse_rec_sel(); pulse_play_sel();
        checks++;
        if (rec_clip !== 2'd2 || play_clip !== 2'd2) begin
            errors++; $display("FAIL select_while_busy rec=%0d play=%0d required 2 2", rec_clip, play_clip);
        end
        for (int i = 0; i < 3; i++) begin
            des_data = vals[i];
            des_done = 1'b1;
            exp_wr_q.push_back({2'd2, 12'(i), vals[i]});
            tick();
            // Second sample holds done into the write cycle, which must be dropped.
            if (i == 1) tick();
            des_done = 1'b0;
            tick(); tick();
        end
        rec_cmd = 1'b1; tick(); rec_cmd = 1'b0; tick();
        checks++;
        if (busy !== 1'b0 || clip_valid !== 4'b0100) begin
            errors++; $display("FAIL rec_stop busy=%b valid=%b required 0 0100", busy, clip_valid);
        end
        checks++;
        if (obs_wr_q.size() !== exp_wr_q.size()) begin
            errors++; $display("FAIL rec_write_count got %0d required %0d", obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            logic [29:0] e, o;
            e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL rec_write addr/data got %h/%h required %h/%h", o[29:16], o[15:0], e[29:16], e[15:0]);
            end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
    endtask

    task automatic test_play(input logic loop, input int n);
        logic [15:0] vals [3];
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
        loop_mode = loop;
        for (int i = 0; i < n; i++) exp_ser_q.push_back(vals[i % 3]);
        play_cmd = 1'b1; tick(); play_cmd = 1'b0;
        for (int i = 0; i < n; i++) begin
            int w;
            logic [15:0] e;
            w = 0;
            while (!ser_en && w < 20) begin tick(); w++; end
            e = exp_ser_q.pop_front();
            checks++;
            if (ser_en !== 1'b1 || ser_data !== e) begin
                errors++; $display("FAIL play_sample[%0d] en=%b data=%h required 1 %h", i, ser_en, ser_data, e);
            end
            if (i == 0) begin
                tick(); tick();
                checks++;
                if (ser_en !== 1'b1 || ser_data !== e) begin
                    errors++; $display("FAIL play_hold en=%b data=%h required 1 %h", ser_en, ser_data, e);
                end
            end
            if (loop && i == n - 1) begin
                play_cmd = 1'b1; #1;
                checks++;
                if (ser_en !== 1'b0) begin
                    errors++; $display("FAIL play_stop_enable got %b required 0", ser_en);
                end
                tick(); play_cmd = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL play_stop_idle busy=%b required 0", busy);
                end
            end else begin
                ser_done = 1'b1; tick(); ser_done = 1'b0;
                checks++;
                if (!loop && i == n - 1) begin
                    if (busy !== 1'b0) begin
                        errors++; $display("FAIL play_end busy=%b required 0", busy);
                    end
                end else if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {2'd2, 12'((i + 1) % 3)}) begin
                    errors++; $display("FAIL play_read_latency en=%b we=%b addr=%h required 1 0 %h",
                                       mem_en, mem_we, mem_addr, {2'd2, 12'((i + 1) % 3)});
                end
            end
        end
        loop_mode = 1'b0;
        tick();
    endtask

    task automatic test_empty_play();
        pulse_play_sel();
        play_cmd = 1'b1; tick(); play_cmd = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL empty_play busy=%b required 0", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL empty_play_later busy=%b mem_en=%b required 0 0", busy, mem_en);
        end
        for (int i = 0; i < 3; i++) pulse_play_sel();
    endtask

    task automatic test_stop_with_done();
        pulse_rec_sel();
        rec_cmd = 1'b1; tick(); rec_cmd = 1'b0; tick();
        des_data = 16'hABCD; des_done = 1'b1; rec_cmd = 1'b1;
        exp_wr_q.push_back({2'd3, 12'd0, 16'hABCD});
        tick();
        des_done = 1'b0; rec_cmd = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || clip_valid !== 4'b1100) begin
            errors++; $display("FAIL stop_with_done busy=%b valid=%b required 0 1100", busy, clip_valid);
        end
        checks++;
        if (obs_wr_q.size() !== 1 || obs_wr_q[0] !== exp_wr_q[0]) begin
            errors++; $display("FAIL stop_with_done_write count=%0d required 1 of %h", obs_wr_q.size(), exp_wr_q[0]);
        end
        exp_wr_q.delete(); obs_wr_q.delete();
    endtask

    task automatic test_same_cycle();
        play_cmd = 1'b1; rec_cmd = 1'b1; tick(); play_cmd = 1'b0; rec_cmd = 1'b0;
        checks++;
        if (des_en !== 1'b1 || ser_en !== 1'b0 || mem_en !== 1'b0 || clip_valid !== 4'b0100) begin
            errors++; $display("FAIL record_wins des_en=%b mem_en=%b valid=%b required 1 0 0100", des_en, mem_en, clip_valid);
        end
        rec_cmd = 1'b1; tick(); rec_cmd = 1'b0; tick();
        checks++;
        if (busy !== 1'b0 || clip_valid !== 4'b0100 || obs_wr_q.size() !== 0) begin
            errors++; $display("FAIL empty_record_stop busy=%b valid=%b writes=%0d required 0 0100 0", busy, clip_valid, obs_wr_q.size());
        end
    endtask

    task automatic test_full_clip();
        s_rec_cmd = 1'b1; tick(); s_rec_cmd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_des_data = 16'hA0 + 16'(i);
            s_exp_wr_q.push_back({4'(i), 16'hA0 + 16'(i)});
            s_des_done = 1'b1; tick(); s_des_done = 1'b0; tick(); tick();
        end
        checks++;
        if (s_busy !== 1'b0 || s_clip_valid !== 4'b0001) begin
            errors++; $display("FAIL full_auto_idle busy=%b valid=%b required 0 0001", s_busy, s_clip_valid);
        end
        s_des_done = 1'b1; tick(); s_des_done = 1'b0; tick(); tick();
        checks++;
        if (s_obs_wr_q.size() !== 4) begin
            errors++; $display("FAIL full_write_count got %0d required 4", s_obs_wr_q.size());
        end
        while (s_exp_wr_q.size() > 0 && s_obs_wr_q.size() > 0) begin
            logic [19:0] e, o;
            e = s_exp_wr_q.pop_front(); o = s_obs_wr_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL full_write got %h required %h", o, e);
            end
        end
        s_play_cmd = 1'b1; tick(); s_play_cmd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int w;
            w = 0;
            while (!s_ser_en && w < 20) begin tick(); w++; end
            checks++;
            if (s_ser_en !== 1'b1 || s_ser_data !== 16'hA0 + 16'(i)) begin
                errors++; $display("FAIL full_play[%0d] en=%b data=%h required 1 %h", i, s_ser_en, s_ser_data, 16'hA0 + 16'(i));
            end
            s_ser_done = 1'b1; tick(); s_ser_done = 1'b0;
        end
        checks++;
        if (s_busy !== 1'b0) begin
            errors++; $display("FAIL full_length busy=%b required 0 after 4 samples", s_busy);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        play_cmd = 1'b1; tick(); play_cmd = 1'b0;
        w = 0;
        while (!ser_en && w < 20) begin tick(); w++; end
        #3 reset_i = 1'b1; #1;
        checks++;
        if ({busy, play_clip, rec_clip, clip_valid, des_en, ser_en, mem_en, mem_we} !== 13'd0 ||
            {ser_data, mem_addr, mem_wdata} !== 46'd0) begin
            errors++; $display("FAIL reset_in_play busy=%b valid=%b ser_en=%b sdata=%h required 0 0000 0 0000",
                               busy, clip_valid, ser_en, ser_data);
        end
        tick(); reset_i = 1'b0; tick();
        obs_wr_q.delete();
        rec_cmd = 1'b1; tick(); rec_cmd = 1'b0;
        des_data = 16'h5555; des_done = 1'b1; tick(); des_done = 1'b0;
        #2 reset_i = 1'b1; #1;
        checks++;
        if ({busy, des_en, mem_en, mem_we, clip_valid} !== 8'd0 || mem_addr !== 14'd0 || mem_wdata !== 16'd0) begin
            errors++; $display("FAIL reset_in_write busy=%b en=%b we=%b wdata=%h required 0 0 0 0000",
                               busy, mem_en, mem_we, mem_wdata);
        end
        tick(); tick();
        checks++;
        if (obs_wr_q.size() !== 0) begin
            errors++; $display("FAIL reset_partial_write writes=%0d required 0", obs_wr_q.size());
        end
        reset_i = 1'b0; tick();
    endtask

    initial begin
        reset_i = 1'b1; play_cmd = 0; rec_cmd = 0; play_sel = 0; rec_sel = 0; loop_mode = 0;
        des_done = 0; ser_done = 0; des_data = '0;
        s_play_cmd = 0; s_rec_cmd = 0; s_des_done = 0; s_ser_done = 0; s_des_data = '0;
        test_reset();
        test_select_wrap();
        test_record();
        test_play(1'b0, 3);
        test_play(1'b1, 5);
        test_empty_play();
        test_stop_with_done();
        test_same_cycle();
        test_full_clip();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
